// File: rtl/apb_master_bridge.sv
// Core req/gnt/rvalid to APB master bridge. One transfer is outstanding at a time,
// and a pready timeout stops a hung slave from stalling the initiator.
module apb_master_bridge #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic                      timeout_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES < 1) ? '0 : CW'(TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic            grant;
  logic            done;
  logic            expire;

  // Handshake: a request is accepted in the cycle req_i && gnt_o; the response is
  // the single cycle with rvalid_o high, where rdata_o/err_o are valid (0 otherwise).
  assign grant  = (state_q == IDLE) && req_i;
  assign done   = (state_q == ACCESS) && pready_i;
  assign expire = TO_EN && (state_q == ACCESS) && !pready_i && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_i) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done || expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus strobes decode straight from the state register so reset drops them at once.
  always_comb begin
    gnt_o     = 1'b0;
    psel_o    = 1'b0;
    penable_o = 1'b0;
    case (state_q)
      IDLE:    gnt_o = req_i && rst_n;
      SETUP:   psel_o = 1'b1;
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paddr_o  <= '0;
      pwdata_o <= '0;
      pwrite_o <= 1'b0;
    end else if (grant) begin
      paddr_o  <= addr_i;
      pwdata_o <= wdata_i;
      pwrite_o <= we_i;
    end
  end

  // Wait-state counter: cleared in SETUP, saturates rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == SETUP) begin
      cnt_q <= '0;
    end else if ((state_q == ACCESS) && !pready_i && (cnt_q != {CW{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_o  <= 1'b0;
      err_o     <= 1'b0;
      rdata_o   <= '0;
      timeout_o <= 1'b0;
    end else begin
      rvalid_o  <= done || expire;
      err_o     <= done ? pslverr_i : expire;
      rdata_o   <= (done && !pwrite_o) ? prdata_i : '0;
      timeout_o <= expire;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboarded bench for apb_master_bridge with directed APB transfers and an
// 8-cycle timeout instance.
module tb_apb_master_bridge;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        timeout_o;
  logic [31:0] paddr_o;
  logic [31:0] pwdata_o;
  logic        pwrite_o;
  logic        psel_o;
  logic        penable_o;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [33:0] exp_q[$];

  apb_master_bridge #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .addr_i(addr), .we_i(we), .wdata_i(wdata),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .timeout_o(timeout_o), .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o),
    .psel_o(psel_o), .penable_o(penable_o), .prdata_i(prdata), .pready_i(pready),
    .pslverr_i(pslverr)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every response pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rsp_unexpected: got rvalid with empty queue, required none");
        end else begin
          logic [33:0] e;
          e = exp_q.pop_front();
          check("rsp", {err_o, timeout_o, rdata_o}, e);
        end
      end else begin
        check("idle_rsp", {err_o, timeout_o, rdata_o}, 128'd0);
      end
    end
  end

  // Driver: one complete transfer; pready rises on ACCESS cycle index 'waits'.
  task automatic do_xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input int waits, input logic [31:0] rd, input logic se,
                         input bit hold, output int gc);
    int acc;
    bit to;
    logic [31:0] er;
    to = (waits >= 8);
    er = (to || w) ? 32'd0 : rd;
    req = 1'b1; addr = a; we = w; wdata = wd;
    #1;
    check("gnt", gnt_o, 1);
    gc = cyc;
    exp_q.push_back({(to ? 1'b1 : se), to, er});
    @(posedge clk); #1;
    if (hold) begin
      addr = ~a; wdata = ~wd; we = ~w;
    end else begin
      req = 1'b0;
    end
    check("setup_strobes", {psel_o, penable_o, gnt_o}, 3'b100);
    check("setup_fields", {paddr_o, pwdata_o, pwrite_o}, {a, wd, w});
    @(posedge clk); #1;
    acc = 0;
    while (psel_o && penable_o && acc < 300) begin
      check("access_fields", {gnt_o, paddr_o, pwdata_o, pwrite_o}, {1'b0, a, wd, w});
      pready  = (acc == waits);
      prdata  = (acc == waits) ? rd : $urandom;
      pslverr = (acc == waits) ? se : 1'b1;
      acc++;
      @(posedge clk); #1;
    end
    pready  = 1'b0;
    prdata  = $urandom;
    pslverr = 1'($urandom_range(0, 1));
    check("access_count", acc, to ? 8 : waits + 1);
    check("rsp_strobes", {rvalid_o, psel_o, penable_o}, 3'b100);
    check("rsp_latency", cyc - gc, 2 + (to ? 8 : waits + 1));
  endtask

  initial begin
    int g0, g1;
    rst_n = 1'b0; req = 1'b1; addr = 32'h1234_5678; we = 1'b1; wdata = 32'hFFFF_0000;
    prdata = 32'h5555_AAAA; pready = 1'b1; pslverr = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("reset_outputs",
          {gnt_o, rvalid_o, rdata_o, err_o, timeout_o, paddr_o, pwdata_o, pwrite_o, psel_o, penable_o},
          128'd0);
    rst_n = 1'b1; req = 1'b0; pready = 1'b0; pslverr = 1'b0;
    @(posedge clk); #1;

    do_xfer(32'h1A10_1000, 1'b0, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, g0);
    do_xfer(32'h1A10_3004, 1'b1, 32'h0000_00A5, 4, 32'h7777_7777, 1'b0, 1'b0, g0);
    do_xfer(32'h1A10_2008, 1'b0, 32'h0, 1, 32'h1234_5678, 1'b1, 1'b0, g0);
    do_xfer(32'h1A10_4000, 1'b0, 32'h0, 100, 32'hBAD0_BAD0, 1'b0, 1'b0, g0);
    do_xfer(32'h1A10_4004, 1'b0, 32'h0, 7, 32'hCAFE_F00D, 1'b0, 1'b0, g0);

    do_xfer(32'h1A10_7000, 1'b1, 32'h0000_5A5A, 0, 32'h0, 1'b0, 1'b1, g0);
    do_xfer(32'h1A10_7000, 1'b0, 32'h0, 0, 32'h0F0F_0F0F, 1'b0, 1'b0, g1);
    check("b2b_cadence", g1 - g0, 3);

    req = 1'b1; addr = 32'h1A10_5000; we = 1'b0; wdata = 32'h0;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_access", {psel_o, penable_o}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_strobes", {psel_o, penable_o, rvalid_o}, 3'b000);
    @(posedge clk); #1;
    check("reset_no_rvalid", rvalid_o, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", {rvalid_o, psel_o, penable_o}, 3'b000);
    do_xfer(32'h1A10_6010, 1'b0, 32'h0, 2, 32'h600D_600D, 1'b0, 1'b0, g0);

    @(posedge clk); @(posedge clk); #1;
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts the core-side req/gnt/rvalid data interface into APB master transactions. One transfer is outstanding at a time.
- Sits between a core or debug port and the SoC peripheral APB interconnect, which decodes UART, GPIO, SPI and the other peripherals.
- Drives the Master side of the APB bus and adds a pready timeout so that a hung slave cannot lock up the initiator.

Parameters:
- APB_ADDR_WIDTH, 32, width of addr_i and paddr_o.
- APB_DATA_WIDTH, 32, width of wdata_i, rdata_o, pwdata_o and prdata_i.
- TIMEOUT_CYCLES, 255, number of ACCESS cycles with pready low before the bridge aborts the transfer. A value of 0 disables the timeout.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_i  input  1  core request.
- addr_i  input  APB_ADDR_WIDTH  request address.
- we_i  input  1  1 = write, 0 = read.
- wdata_i  input  APB_DATA_WIDTH  write data.
- gnt_o  output  1  request accepted this cycle.
- rvalid_o  output  1  one-cycle response pulse.
- rdata_o  output  APB_DATA_WIDTH  read data, valid while rvalid_o is high.
- err_o  output  1  response error, valid while rvalid_o is high.
- timeout_o  output  1  one-cycle pulse when a transfer is aborted by timeout.
- paddr_o  output  APB_ADDR_WIDTH  APB address.
- pwdata_o  output  APB_DATA_WIDTH  APB write data.
- pwrite_o  output  1  APB write strobe.
- psel_o  output  1  APB select.
- penable_o  output  1  APB enable.
- prdata_i  input  APB_DATA_WIDTH  APB read data.
- pready_i  input  1  APB ready.
- pslverr_i  input  1  APB slave error.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE; the timeout counter is cleared.
  - All outputs are 0: gnt_o, rvalid_o, rdata_o, err_o, timeout_o, paddr_o, pwdata_o, pwrite_o, psel_o, penable_o.
  - Reset in the middle of a transfer drops psel_o and penable_o immediately and produces no rvalid_o.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - gnt_o = req_i, combinational. gnt_o is never high in SETUP or ACCESS.
  - When req_i is high, addr_i, we_i and wdata_i are registered into paddr_o, pwrite_o and pwdata_o, and the next state is SETUP.
  - Request inputs are sampled only on the grant cycle.
- SETUP (exactly 1 cycle): psel_o=1, penable_o=0. Next state is ACCESS; the timeout counter is cleared.
- ACCESS: psel_o=1, penable_o=1.
  - pready_i=1: the transfer completes and the next state is IDLE.
    - Next cycle: rvalid_o=1 and err_o=pslverr_i.
    - rdata_o = prdata_i for reads, 0 for writes.
  - pready_i=0: the timeout counter increments.
  - Timeout: when TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 with pready_i=0, the transfer aborts and the next state is IDLE.
    - Next cycle: rvalid_o=1, err_o=1, rdata_o=0, timeout_o=1.
  - pready_i=1 in the same cycle as the timeout threshold: pready wins and the transfer completes normally with timeout_o=0.
  - Counter width is $clog2(TIMEOUT_CYCLES+1), with a minimum of 1. The counter saturates and never wraps.
- paddr_o, pwrite_o and pwdata_o stay stable from SETUP through the end of ACCESS. After completion they hold their last value; they do not return to 0.
- rvalid_o and timeout_o are single-cycle pulses. rdata_o and err_o return to 0 when rvalid_o is low.
- Latency, with the grant in cycle 0 and zero APB wait states:
  - SETUP in cycle 1, ACCESS in cycle 2, rvalid_o in cycle 3.
  - Each APB wait state adds 1 cycle.
- Back-to-back transfers:
  - The rvalid_o cycle is an IDLE cycle, so a new grant can occur in that same cycle.
  - Peak throughput is 1 transfer per 3 cycles.
- prdata_i and pslverr_i are ignored outside the ACCESS-completion cycle.
- Addresses are passed through unmodified: no alignment and no range checking.

Test Plan:
- Read from 0x1A10_1000, pready high in the first ACCESS cycle, prdata=0xDEAD_BEEF → gnt in c0; psel=1/penable=0 in c1; psel=1/penable=1 in c2; rvalid=1, rdata=0xDEAD_BEEF, err=0 in c3.
- Write 0x0000_00A5 to 0x1A10_3004 with 4 wait states → pwrite=1, pwdata=0xA5 and paddr stable for all 5 ACCESS cycles; rvalid with rdata=0 follows the pready cycle.
- Read with pslverr=1 at completion → rvalid=1, err=1, rdata=prdata.
- TIMEOUT_CYCLES=8, pready held low → exactly 8 ACCESS cycles, then psel drops; rvalid=1, err=1, timeout_o=1, rdata=0. A variant with pready=1 on the 8th ACCESS cycle completes normally with timeout_o=0.
- Two requests held continuously (write then read to 0x1A10_7000) → grants in c0 and c3, 3-cycle cadence, responses in c3 and c6, in order.
- rst_n pulsed low in ACCESS → psel/penable go to 0 asynchronously, no rvalid, the bridge returns to IDLE; the next request completes normally.
